// File: rtl/seq_scheduler_if.sv
// Host base-stream handshake between the sequence source and the scheduler.
// The host drives the base and framing; the scheduler answers with ready.
interface seq_scheduler_if #(
  parameter int BP_W = 2
) ();
  logic            in_valid;
  logic [BP_W-1:0] in_bp;
  logic            in_last;
  logic            in_ready;

  modport master (output in_valid, output in_bp, output in_last, input in_ready);
  modport slave  (input in_valid, input in_bp, input in_last, output in_ready);
endinterface

// File: rtl/seq_scheduler.sv
// Job sequencer for a systolic alignment array: loads the query into the PEs,
// streams the target with DP backpressure, then waits for DP and traceback.
module seq_scheduler #(
  parameter int N      = 32,
  parameter int LOG_N  = 5,
  parameter int BP_W   = 2,
  parameter int TLEN_W = 16
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              start,
  input  logic [LOG_N-1:0]  q_len,
  seq_scheduler_if.slave    host,
  output logic [BP_W-1:0]   S,
  output logic              s_update,
  output logic [BP_W-1:0]   T,
  output logic              valid,
  output logic [LOG_N-1:0]  PE_end,
  output logic              new_seq,
  input  logic              busy,
  input  logic              tb_busy,
  output logic              done,
  output logic [TLEN_W-1:0] t_count
);

  typedef enum logic [2:0] {IDLE, LOAD_S, STREAM_T, DRAIN, SWAP} state_e;

  // A query longer than the array is clamped to the last PE.
  localparam logic [LOG_N-1:0] PE_MAX = LOG_N'(N - 1);

  state_e             state_q, state_d;
  logic [BP_W-1:0]    s_q, s_d, t_q, t_d;
  logic               s_update_q, s_update_d, valid_q, valid_d;
  logic               new_seq_q, new_seq_d, done_q, done_d;
  logic [LOG_N-1:0]   pe_end_q, pe_end_d, cnt_q, cnt_d;
  logic [TLEN_W-1:0]  t_count_q, t_count_d;
  logic               in_ready;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    t_d        = t_q;
    s_update_d = 1'b0;
    valid_d    = 1'b0;
    new_seq_d  = 1'b0;
    done_d     = 1'b0;
    pe_end_d   = pe_end_q;
    t_count_d  = t_count_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pe_end_d  = (q_len > PE_MAX) ? PE_MAX : q_len;
          cnt_d     = '0;
          t_count_d = '0;
          state_d   = LOAD_S;
        end
      end
      LOAD_S: begin
        in_ready = 1'b1;
        if (host.in_valid) begin
          s_d        = host.in_bp;
          s_update_d = 1'b1;
          if (cnt_q == pe_end_q) begin
            cnt_d   = '0;
            state_d = STREAM_T;
          end else begin
            cnt_d = cnt_q + LOG_N'(1);
          end
        end
      end
      STREAM_T: begin
        in_ready = !busy;
        if (host.in_valid && !busy) begin
          t_d       = host.in_bp;
          valid_d   = 1'b1;
          t_count_d = (t_count_q == '1) ? t_count_q : t_count_q + TLEN_W'(1);
          if (host.in_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!busy) state_d = SWAP;
      end
      SWAP: begin
        // Hand the PEs to the next job only once traceback has released them.
        if (!tb_busy) begin
          new_seq_d = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      s_q        <= '0;
      t_q        <= '0;
      s_update_q <= 1'b0;
      valid_q    <= 1'b0;
      new_seq_q  <= 1'b0;
      done_q     <= 1'b0;
      pe_end_q   <= '0;
      t_count_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      t_q        <= t_d;
      s_update_q <= s_update_d;
      valid_q    <= valid_d;
      new_seq_q  <= new_seq_d;
      done_q     <= done_d;
      pe_end_q   <= pe_end_d;
      t_count_q  <= t_count_d;
      cnt_q      <= cnt_d;
    end
  end

  assign host.in_ready = in_ready;
  assign S             = s_q;
  assign T             = t_q;
  assign s_update      = s_update_q;
  assign valid         = valid_q;
  assign new_seq       = new_seq_q;
  assign done          = done_q;
  assign PE_end        = pe_end_q;
  assign t_count       = t_count_q;

endmodule

// File: tb/tb_seq_scheduler.sv
// Randomized bench for seq_scheduler: jobs are described as base lists and
// timing knobs, and the expected outputs are derived from those lists.
module tb_seq_scheduler;
  localparam int LOG_N  = 5;
  localparam int BP_W   = 2;
  localparam int TLEN_W = 4;
  localparam int TSAT   = (1 << TLEN_W) - 1;

  logic              clk = 1'b0;
  logic              reset_i = 1'b0;
  logic              start = 1'b0;
  logic [LOG_N-1:0]  q_len = '0;
  logic [BP_W-1:0]   S, T;
  logic              s_update, valid, new_seq, done;
  logic [LOG_N-1:0]  PE_end;
  logic              busy = 1'b0, tb_busy = 1'b0;
  logic [TLEN_W-1:0] t_count;

  seq_scheduler_if #(.BP_W(BP_W)) host ();

  seq_scheduler #(.N(32), .LOG_N(LOG_N), .BP_W(BP_W), .TLEN_W(TLEN_W)) dut (
    .clk(clk), .reset_i(reset_i), .start(start), .q_len(q_len), .host(host),
    .S(S), .s_update(s_update), .T(T), .valid(valid), .PE_end(PE_end),
    .new_seq(new_seq), .busy(busy), .tb_busy(tb_busy), .done(done), .t_count(t_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Monitor: logs every base the DUT presents to the DP and every pulse.
  int cyc = 0;
  logic [BP_W-1:0] s_log[$], t_log[$];
  int ns_cnt, done_cnt, ns_cyc, overlap, pulse_mis, ns_double;
  logic prev_ns = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (s_update) s_log.push_back(S);
    if (valid) t_log.push_back(T);
    if (s_update && valid) overlap++;
    if (new_seq !== done) pulse_mis++;
    if (done) done_cnt++;
    if (new_seq) begin
      ns_cnt++;
      ns_cyc = cyc;
      if (prev_ns) ns_double++;
    end
    prev_ns = new_seq;
  end

  int rdy_err, bp_left, last_p;
  bit stalled;

  // Offers one base until it is accepted; query phase expects ready=1, target phase !busy.
  task automatic send_base(input bit is_t, input logic [BP_W-1:0] b, input bit last,
                           input bit rnd, input bit first);
    bit sent = 0;
    int guard = 0;
    while (!sent && !stalled) begin
      @(negedge clk);
      host.in_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
      host.in_bp    = b;
      host.in_last  = is_t ? last : (rnd ? 1'($urandom) : 1'b0);
      start         = rnd && (first || $urandom_range(7) == 0);
      q_len         = LOG_N'($urandom);
      if (is_t && bp_left > 0) begin
        busy = 1'b1;
        bp_left--;
      end else begin
        busy = is_t ? (rnd && $urandom_range(3) == 0) : 1'($urandom);
      end
      #1;
      if (host.in_ready !== (is_t ? !busy : 1'b1)) rdy_err++;
      sent = host.in_valid && host.in_ready;
      if (sent) last_p = cyc + 1;
      guard++;
      if (guard > 64) begin
        check("base_accept_timeout", 1, 0);
        stalled = 1;
      end
    end
  endtask

  task automatic run_job(input int ql, input int nt, input bit rnd, input int d,
                         input int h, input int bp_at, input int abort_at);
    logic [BP_W-1:0] exp_s[$], exp_t[$];
    int e_edge, span;
    exp_s.delete(); exp_t.delete();
    for (int i = 0; i <= ql; i++) exp_s.push_back(rnd ? BP_W'($urandom) : BP_W'(i));
    for (int i = 0; i < nt; i++) exp_t.push_back(rnd ? BP_W'($urandom) : BP_W'(nt - i));

    @(negedge clk);
    s_log.delete(); t_log.delete();
    ns_cnt = 0; done_cnt = 0; ns_cyc = -1; overlap = 0; pulse_mis = 0; ns_double = 0;
    rdy_err = 0; bp_left = 0; stalled = 0;
    busy = 1'b0; tb_busy = 1'b0; host.in_valid = 1'b0;
    start = 1'b1; q_len = LOG_N'(ql);
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i <= ql; i++) send_base(0, exp_s[i], 0, rnd, i == 0);
    for (int i = 0; i < nt; i++) begin
      if (i == bp_at) bp_left = 3;
      if (abort_at > 0 && i == abort_at) begin
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("rst_S", S, 0);
        check("rst_T", T, 0);
        check("rst_s_update", s_update, 0);
        check("rst_valid", valid, 0);
        check("rst_new_seq", new_seq, 0);
        check("rst_done", done, 0);
        check("rst_pe_end", PE_end, 0);
        check("rst_t_count", t_count, 0);
        check("rst_in_ready", host.in_ready, 0);
        check("rst_t_seen", t_log.size(), abort_at);
        @(negedge clk);
        reset_i = 1'b1; host.in_valid = 1'b0; start = 1'b0; busy = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_new_seq", ns_cnt, 0);
        check("abort_done", done_cnt, 0);
        check("abort_idle_ready", host.in_ready, 0);
        return;
      end
      send_base(1, exp_t[i], i == nt - 1, rnd, i == 0);
    end

    span = ((d > h) ? d : h) + 6;
    for (int k = 1; k <= span; k++) begin
      @(negedge clk);
      host.in_valid = 1'b0; host.in_last = 1'b0; start = 1'b0;
      busy    = (k <= d);
      tb_busy = (k <= h);
    end
    e_edge = last_p + (((d + 2) > (h + 1)) ? (d + 2) : (h + 1));

    check("s_count", s_log.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < s_log.size(); i++) check("s_val", s_log[i], exp_s[i]);
    check("t_count_stream", t_log.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < t_log.size(); i++) check("t_val", t_log[i], exp_t[i]);
    check("t_count", t_count, (nt > TSAT) ? TSAT : nt);
    check("pe_end", PE_end, ql);
    check("new_seq_pulses", ns_cnt, 1);
    check("done_pulses", done_cnt, 1);
    check("pulse_cycle", ns_cyc, e_edge);
    check("pulse_align", pulse_mis, 0);
    check("pulse_width", ns_double, 0);
    check("supd_valid_overlap", overlap, 0);
    check("in_ready_rule", rdy_err, 0);
    check("idle_ready", host.in_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    host.in_valid = 1'b0; host.in_bp = '0; host.in_last = 1'b0;
    #13;
    check("reset_S", S, 0);
    check("reset_T", T, 0);
    check("reset_flags", {s_update, valid, new_seq, done}, 0);
    check("reset_pe_end", PE_end, 0);
    check("reset_t_count", t_count, 0);
    check("reset_in_ready", host.in_ready, 0);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);

    run_job(3, 5, 0, 0, 0, -1, 0);    // basic job
    run_job(2, 6, 0, 0, 0, 2, 0);     // 3-cycle busy mid-target
    run_job(1, 3, 0, 1, 10, -1, 0);   // traceback hold
    run_job(0, 1, 0, 0, 0, -1, 0);    // shortest query and target
    run_job(2, 6, 1, 0, 0, -1, 2);    // reset after 2 target bases
    run_job(4, 4, 0, 0, 0, -1, 0);    // follow-up job counts from 0
    run_job(31, 3, 1, 2, 0, -1, 0);   // full-length query, stray starts
    run_job(1, 20, 1, 0, 3, -1, 0);   // t_count saturation
    for (int j = 0; j < 12; j++)
      run_job($urandom_range(7), 1 + $urandom_range(9), 1, $urandom_range(3),
              $urandom_range(5), -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seq_scheduler.md
SEQ_SCHEDULER -- requirements
Module: seq_scheduler

Interface
REQ-001 SHALL have parameter N, default 32: PE count of the systolic array.
REQ-002 SHALL have parameter LOG_N, default 5: width of query-length/PE index.
REQ-003 SHALL have parameter BP_W, default 2: base-pair width.
REQ-004 SHALL have parameter TLEN_W, default 16: target-length counter width.
REQ-005 SHALL have ports clk in 1 (single clock) and reset_i in 1 (asynchronous, active-low reset).
REQ-006 SHALL have port start in 1: pulse that begins one alignment job.
REQ-007 SHALL have port q_len in LOG_N: query length minus 1, sampled on start.
REQ-008 SHALL have ports in_valid in 1, in_bp in BP_W, in_last in 1, in_ready out 1: host base stream.
REQ-009 SHALL have ports S out BP_W and s_update out 1: query load to DP.
REQ-010 SHALL have ports T out BP_W and valid out 1: target stream to DP.
REQ-011 SHALL have ports PE_end out LOG_N and new_seq out 1: DP job control.
REQ-012 SHALL have ports busy in 1 and tb_busy in 1: status from DP and the traceback unit.
REQ-013 SHALL have ports done out 1 (one-cycle job-complete pulse) and t_count out TLEN_W (target bases accepted).

Function
REQ-014 SHALL implement states IDLE, LOAD_S, STREAM_T, DRAIN and SWAP.
REQ-015 SHALL register S, T, s_update, valid, new_seq, done, PE_end and t_count.
REQ-016 SHALL define a transfer as in_valid and in_ready high on the same rising edge.
REQ-017 In IDLE: in_ready=0; start=1 SHALL load PE_end<=q_len, clear the base counter and t_count, and enter LOAD_S.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 In LOAD_S: in_ready=1; each transfer SHALL set S<=in_bp and s_update=1 on the next cycle.
REQ-020 In LOAD_S, s_update SHALL be 0 in any cycle following a non-transfer.
REQ-021 In LOAD_S, the transfer at which the base counter equals PE_end SHALL move the block to STREAM_T and clear the counter.
REQ-022 in_last SHALL be ignored in LOAD_S.
REQ-023 In STREAM_T: in_ready SHALL equal !busy (combinational).
REQ-024 In STREAM_T, each transfer SHALL set T<=in_bp and valid=1 on the next cycle, and increment t_count, saturating at all-ones.
REQ-025 In STREAM_T, valid SHALL be 0 after a non-transfer cycle.
REQ-026 A transfer with in_last=1 in STREAM_T SHALL enter DRAIN; a one-base target is legal.
REQ-027 In DRAIN: in_ready=0; the block SHALL stay until busy=0, then enter SWAP.
REQ-028 In SWAP: in_ready=0; the block SHALL wait while tb_busy=1.
REQ-029 In SWAP, the first cycle with tb_busy=0 SHALL produce a registered one-cycle pulse on both new_seq and done, and return to IDLE.
REQ-030 new_seq SHALL never be high while tb_busy=1 was sampled high in the same cycle.
REQ-031 new_seq SHALL never be high for more than one consecutive cycle.
REQ-032 S, T, PE_end and t_count SHALL hold their values between updates; t_count SHALL remain readable in IDLE until the next start.
REQ-033 s_update and valid SHALL never be high in the same cycle.

Reset
REQ-034 reset_i=0 SHALL immediately force IDLE and drive S=0, T=0, s_update=0, valid=0, new_seq=0, done=0, PE_end=0, t_count=0 and in_ready=0.
REQ-035 Reset asserted mid-job (any state) SHALL abort the job with no new_seq or done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-036 Basic job: q_len=3, then 4 query bases 0,1,2,3 back-to-back, then 5 target bases with last on the 5th, busy=0, tb_busy=0 -> s_update high 4 cycles with S=0..3; valid high 5 cycles; t_count=5; PE_end=3; exactly one new_seq/done pulse.
REQ-037 Backpressure: busy=1 for 3 cycles mid-target -> in_ready=0 during those cycles, no valid, no lost or duplicated base; final t_count matches bases sent.
REQ-038 Traceback hold: tb_busy=1 for 10 cycles when SWAP is entered -> new_seq stays 0 for those cycles, then pulses one cycle after tb_busy falls.
REQ-039 Edge lengths: q_len=0 with a single-base target (in_last on the first T) -> one s_update, one valid, then DRAIN and SWAP, one new_seq pulse.
REQ-040 Reset mid-STREAM_T after 2 bases -> all outputs 0, no new_seq; a following job completes normally with t_count counted from 0.
REQ-041 start pulses during LOAD_S and during STREAM_T -> ignored; PE_end unchanged and the job completes once.
